pe_sequencer: RTL and testbench
===============================

# pe_sequencer

Controller that runs one dot-product job on a single PE: clears it, streams a weight vector from the weight buffer into `w`, then streams an input vector from the input buffer into `in`. After the last input it waits a fixed pipeline drain and captures the PE result. It sits between the top-level job scheduler (start/done handshake) and one PE plus its two synchronous-read buffers.

## Interface
- `DATA_W`, 8: width of the weight and input elements driven into the PE.
- `OUT_W`, 8: width of the PE result.
- `DEPTH`, 32: maximum vector length, and the depth of each buffer.
- `ADDR_W`, 6: buffer address width and length-field width; must satisfy 2^ADDR_W > DEPTH.
- `PE_LAT`, 2: cycles from the last input presented to a valid `pe_out`; must be ≥1.

Ports:
- `clk`, in, 1: single clock; all logic is on the rising edge.
- `reset`, in, 1: synchronous, active-high.
- `start`, in, 1: job request; sampled only in IDLE.
- `vec_len`, in, ADDR_W: element count L, sampled with `start`; 0 or >DEPTH is treated as DEPTH.
- `busy`, out, 1: a job is in progress.
- `done`, out, 1: one-cycle completion pulse.
- `wbuf_rd`, out, 1: weight buffer read enable.
- `wbuf_addr`, out, ADDR_W: weight buffer address.
- `wbuf_data`, in, DATA_W: weight read data, valid the cycle after `wbuf_rd`.
- `ibuf_rd`, out, 1: input buffer read enable.
- `ibuf_addr`, out, ADDR_W: input buffer address.
- `ibuf_data`, in, DATA_W: input read data, 1-cycle read latency.
- `pe_reset`, out, 1: clear to the PE.
- `pe_w`, out, DATA_W: weight bus to the PE.
- `pe_in`, out, DATA_W: input bus to the PE.
- `pe_out`, in, OUT_W: PE result.
- `result`, out, OUT_W: captured result; held until the next capture.
- `result_valid`, out, 1: one-cycle pulse, coincident with `done`.

## Operation
- States are IDLE, CLR, LOAD_W, LOAD_I, DRAIN.
  - IDLE→CLR on `start`.
  - CLR→LOAD_W after 1 cycle.
  - LOAD_W→LOAD_I after L cycles.
  - LOAD_I→DRAIN after L cycles.
  - DRAIN→IDLE after PE_LAT cycles.
- A single element counter (0..L-1) and a drain counter sequence the phases. The latched L is held for the whole job.
- `pe_reset` is 1 in CLR only.
- `pe_w` = `wbuf_data` in LOAD_W, else 0. `pe_in` = `ibuf_data` in LOAD_I, else 0. These are gated combinationally so the PE sees data on consecutive cycles with no bubble.
- Reads are issued one cycle ahead of use:
  - `wbuf_rd` is high in CLR and in the first L-1 LOAD_W cycles, with addresses 0..L-1.
  - `ibuf_rd` is high in the last LOAD_W cycle and in the first L-1 LOAD_I cycles, with addresses 0..L-1.
  - Addresses read 0 whenever the matching rd is low.
- `result` <= `pe_out` at the clock edge ending the last DRAIN cycle. `result_valid` and `done` are registered and pulse in the following (IDLE) cycle.
- `start` is ignored while `busy`; there is no queueing. A `start` in the same cycle as `done` is accepted.
- `reset` has priority everywhere, including mid-job:
  - next cycle, state is IDLE and all outputs are 0, including `result`;
  - no `done` is produced for the aborted job.

## Timing
- Cycle 0 is `start` accepted. Then:
  - CLR: cycle 1.
  - LOAD_W: cycles 2..L+1.
  - LOAD_I: cycles L+2..2L+1.
  - DRAIN: cycles 2L+2..2L+1+PE_LAT.
  - `done` / `result_valid`: cycle 2L+2+PE_LAT.
- `busy` is high in cycles 1..2L+1+PE_LAT.
- Full-length job with defaults (L=32, PE_LAT=2): `done` at cycle 68. Back-to-back throughput is 2L+2+PE_LAT cycles per job.
- L=1 case: LOAD_W and LOAD_I are single cycles; `wbuf_rd` is high only in CLR, and `ibuf_rd` only in the LOAD_W cycle.

## Structure
- Shared package/header `pe_pkg` holds:
  - the state encoding (3-bit localparams);
  - the DATA_W/OUT_W/DEPTH/ADDR_W defaults;
  - a `LEN_CLAMP` helper function.
- No sub-module is needed; the PE and buffers are instantiated by the parent. Expected size is about 150–250 lines.

## Test plan
- Reset then `start` with `vec_len`=32, weights FE,6B,F0,…,C2 and inputs 35,02,D5,…,09 → `wbuf_addr` 0..31 in cycles 1..32; `pe_w` matches the buffer in cycles 2..33; `pe_in` matches in 34..65; `done` and `result_valid` in cycle 68; `result` equals the reference-model PE output.
- `vec_len`=1 → exactly one `pe_w` cycle (2) and one `pe_in` cycle (3); `done` in cycle 6.
- `vec_len`=0 and `vec_len`=40 → both run as L=32; `done` in cycle 68.
- `start` held high throughout → second job's CLR follows the `done` cycle of the first; no `start` is accepted while `busy`.
- `reset` asserted in cycle 20 of a job → cycle 21: IDLE, all outputs 0, `busy`=0, no `done`; a fresh `start` then completes normally.
- `PE_LAT`=1 override with L=4 → `done` in cycle 11; `result` is `pe_out` as sampled at the end of cycle 10.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared definitions for the PE job sequencer: state encoding, default widths
// and the vector-length clamp helper.
package pe_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned OUT_W_DEF  = 8;
  localparam int unsigned DEPTH_DEF  = 32;
  localparam int unsigned ADDR_W_DEF = 6;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLR    = 3'd1,
    ST_LOAD_W = 3'd2,
    ST_LOAD_I = 3'd3,
    ST_DRAIN  = 3'd4
  } state_t;

  // A zero or oversized length means "full buffer".
  function automatic int unsigned LEN_CLAMP(input int unsigned len, input int unsigned depth);
    return ((len == 0) || (len > depth)) ? depth : len;
  endfunction

endpackage

// File: rtl/pe_sequencer.sv
// Runs one dot-product job on a PE: clear, stream weights, stream inputs,
// wait out the PE pipeline, then capture the result.
module pe_sequencer
  import pe_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned OUT_W  = OUT_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned PE_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] vec_len,
  output logic              busy,
  output logic              done,
  output logic              wbuf_rd,
  output logic [ADDR_W-1:0] wbuf_addr,
  input  logic [DATA_W-1:0] wbuf_data,
  output logic              ibuf_rd,
  output logic [ADDR_W-1:0] ibuf_addr,
  input  logic [DATA_W-1:0] ibuf_data,
  output logic              pe_reset,
  output logic [DATA_W-1:0] pe_w,
  output logic [DATA_W-1:0] pe_in,
  input  logic [OUT_W-1:0]  pe_out,
  output logic [OUT_W-1:0]  result,
  output logic              result_valid
);

  localparam int unsigned DCNT_W = (PE_LAT > 1) ? $clog2(PE_LAT) : 1;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;
  logic [ADDR_W-1:0] len_m1, len_m1_nxt;
  logic [DCNT_W-1:0] dcnt, dcnt_nxt;
  logic              done_nxt;
  logic [OUT_W-1:0]  result_nxt;

  // Next state, counters and decoded outputs; reads run one cycle ahead of use.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    len_m1_nxt = len_m1;
    dcnt_nxt   = dcnt;
    done_nxt   = 1'b0;
    result_nxt = result;
    busy       = 1'b0;
    wbuf_rd    = 1'b0;
    wbuf_addr  = '0;
    ibuf_rd    = 1'b0;
    ibuf_addr  = '0;
    pe_reset   = 1'b0;
    pe_w       = '0;
    pe_in      = '0;

    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt  = ST_CLR;
          len_m1_nxt = ADDR_W'(LEN_CLAMP(32'(vec_len), DEPTH) - 32'd1);
          cnt_nxt    = '0;
          dcnt_nxt   = '0;
        end
      end
      ST_CLR: begin
        busy      = 1'b1;
        pe_reset  = 1'b1;
        wbuf_rd   = 1'b1;
        cnt_nxt   = '0;
        state_nxt = ST_LOAD_W;
      end
      ST_LOAD_W: begin
        busy = 1'b1;
        pe_w = wbuf_data;
        if (cnt == len_m1) begin
          // Prefetch input element 0 so LOAD_I starts without a bubble.
          ibuf_rd   = 1'b1;
          cnt_nxt   = '0;
          state_nxt = ST_LOAD_I;
        end else begin
          wbuf_rd   = 1'b1;
          wbuf_addr = ADDR_W'(cnt + 1'b1);
          cnt_nxt   = ADDR_W'(cnt + 1'b1);
        end
      end
      ST_LOAD_I: begin
        busy  = 1'b1;
        pe_in = ibuf_data;
        if (cnt == len_m1) begin
          dcnt_nxt  = '0;
          state_nxt = ST_DRAIN;
        end else begin
          ibuf_rd   = 1'b1;
          ibuf_addr = ADDR_W'(cnt + 1'b1);
          cnt_nxt   = ADDR_W'(cnt + 1'b1);
        end
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (dcnt == DCNT_W'(PE_LAT - 1)) begin
          done_nxt   = 1'b1;
          result_nxt = pe_out;
          state_nxt  = ST_IDLE;
        end else begin
          dcnt_nxt = DCNT_W'(dcnt + 1'b1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      len_m1       <= '0;
      dcnt         <= '0;
      done         <= 1'b0;
      result_valid <= 1'b0;
      result       <= '0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      len_m1       <= len_m1_nxt;
      dcnt         <= dcnt_nxt;
      done         <= done_nxt;
      result_valid <= done_nxt;
      result       <= result_nxt;
    end
  end

endmodule

// File: tb/tb_pe_sequencer.sv
// Bench for pe_sequencer: two instances (default PE_LAT and PE_LAT=1), each with
// its own buffer read ports and a simple accumulating PE model.
module tb_pe_sequencer;
  import pe_pkg::*;

  localparam int unsigned DW = 8;
  localparam int unsigned OW = 8;
  localparam int unsigned AW = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          start_v  [2];
  logic [AW-1:0] vlen_v   [2];
  logic          busy_v   [2];
  logic          done_v   [2];
  logic          wrd_v    [2];
  logic          ird_v    [2];
  logic          prst_v   [2];
  logic          rv_v     [2];
  logic [AW-1:0] waddr_v  [2];
  logic [AW-1:0] iaddr_v  [2];
  logic [DW-1:0] wdat_v   [2];
  logic [DW-1:0] idat_v   [2];
  logic [DW-1:0] pew_v    [2];
  logic [DW-1:0] pein_v   [2];
  logic [OW-1:0] peout_v  [2];
  logic [OW-1:0] res_v    [2];
  logic [7:0]    acc      [2];
  logic [7:0]    pipe0;
  logic [7:0]    wmem     [64];
  logic [7:0]    imem     [64];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pe_sequencer u_dut (
    .clk(clk), .reset(reset), .start(start_v[0]), .vec_len(vlen_v[0]),
    .busy(busy_v[0]), .done(done_v[0]),
    .wbuf_rd(wrd_v[0]), .wbuf_addr(waddr_v[0]), .wbuf_data(wdat_v[0]),
    .ibuf_rd(ird_v[0]), .ibuf_addr(iaddr_v[0]), .ibuf_data(idat_v[0]),
    .pe_reset(prst_v[0]), .pe_w(pew_v[0]), .pe_in(pein_v[0]), .pe_out(peout_v[0]),
    .result(res_v[0]), .result_valid(rv_v[0])
  );

  pe_sequencer #(.PE_LAT(1)) u_dut_lat1 (
    .clk(clk), .reset(reset), .start(start_v[1]), .vec_len(vlen_v[1]),
    .busy(busy_v[1]), .done(done_v[1]),
    .wbuf_rd(wrd_v[1]), .wbuf_addr(waddr_v[1]), .wbuf_data(wdat_v[1]),
    .ibuf_rd(ird_v[1]), .ibuf_addr(iaddr_v[1]), .ibuf_data(idat_v[1]),
    .pe_reset(prst_v[1]), .pe_w(pew_v[1]), .pe_in(pein_v[1]), .pe_out(peout_v[1]),
    .result(res_v[1]), .result_valid(rv_v[1])
  );

  // Synchronous-read buffers and PE: acc += 3*w + in, cleared by pe_reset.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (wrd_v[i]) wdat_v[i] <= wmem[waddr_v[i]];
      if (ird_v[i]) idat_v[i] <= imem[iaddr_v[i]];
      acc[i] <= prst_v[i] ? 8'd0 : 8'(acc[i] + 8'(pew_v[i] * 8'd3) + pein_v[i]);
    end
    pipe0 <= acc[0];
  end

  always_comb begin
    peout_v[0] = pipe0;
    peout_v[1] = acc[1];
  end

  function automatic logic [7:0] exp_res(input int len);
    logic [7:0] s;
    s = '0;
    for (int i = 0; i < len; i++) s = 8'(s + 8'(wmem[i] * 3) + imem[i]);
    return s;
  endfunction

  task automatic chk(input string nm, input int cyc, input int act, input int expv);
    n_chk++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, expv);
    end
  endtask

  task automatic chk_quiet(input int sel, input int cyc, input bit with_res);
    chk("busy_q",  cyc, 32'(busy_v[sel]),  0);
    chk("done_q",  cyc, 32'(done_v[sel]),  0);
    chk("rv_q",    cyc, 32'(rv_v[sel]),    0);
    chk("wrd_q",   cyc, 32'(wrd_v[sel]),   0);
    chk("waddr_q", cyc, 32'(waddr_v[sel]), 0);
    chk("ird_q",   cyc, 32'(ird_v[sel]),   0);
    chk("iaddr_q", cyc, 32'(iaddr_v[sel]), 0);
    chk("prst_q",  cyc, 32'(prst_v[sel]),  0);
    chk("pew_q",   cyc, 32'(pew_v[sel]),   0);
    chk("pein_q",  cyc, 32'(pein_v[sel]),  0);
    if (with_res) chk("result_q", cyc, 32'(res_v[sel]), 0);
  endtask

  // Entered at the falling edge of an IDLE cycle (job cycle 0); returns at the
  // falling edge of the done cycle.
  task automatic run_job(input int sel, input int vlen, input int len, input int lat,
                         input int done_cyc, input bit hold);
    int e_wa, e_ia, e_pw, e_pi;
    bit e_wrd, e_ird;
    logic [7:0] er;
    er = exp_res(len);
    start_v[sel] = 1'b1;
    vlen_v[sel]  = AW'(vlen);
    for (int c = 1; c <= done_cyc; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (c == 1 && !hold) start_v[sel] = 1'b0;
      e_wrd = (c >= 1) && (c <= len);
      e_ird = (c >= len + 1) && (c <= 2 * len);
      e_wa  = e_wrd ? c - 1 : 0;
      e_ia  = e_ird ? c - len - 1 : 0;
      e_pw  = (c >= 2 && c <= len + 1) ? 32'(wmem[c - 2]) : 0;
      e_pi  = (c >= len + 2 && c <= 2 * len + 1) ? 32'(imem[c - len - 2]) : 0;
      chk("busy",     c, 32'(busy_v[sel]),  32'((c <= 2 * len + 1 + lat) ? 1 : 0));
      chk("pe_reset", c, 32'(prst_v[sel]),  32'((c == 1) ? 1 : 0));
      chk("wbuf_rd",  c, 32'(wrd_v[sel]),   32'(e_wrd));
      chk("wbuf_addr",c, 32'(waddr_v[sel]), e_wa);
      chk("ibuf_rd",  c, 32'(ird_v[sel]),   32'(e_ird));
      chk("ibuf_addr",c, 32'(iaddr_v[sel]), e_ia);
      chk("pe_w",     c, 32'(pew_v[sel]),   e_pw);
      chk("pe_in",    c, 32'(pein_v[sel]),  e_pi);
      chk("done",     c, 32'(done_v[sel]),  32'((c == done_cyc) ? 1 : 0));
      chk("rvalid",   c, 32'(rv_v[sel]),    32'((c == done_cyc) ? 1 : 0));
      if (c == done_cyc) chk("result", c, 32'(res_v[sel]), 32'(er));
    end
  endtask

  typedef struct {
    int sel;
    int vlen;
    int len;
    int lat;
    int done_cyc;
  } vec_t;

  vec_t vecs [6];

  initial begin
    vecs[0] = '{sel: 0, vlen: 32, len: 32, lat: 2, done_cyc: 68};
    vecs[1] = '{sel: 0, vlen: 1,  len: 1,  lat: 2, done_cyc: 6};
    vecs[2] = '{sel: 0, vlen: 0,  len: 32, lat: 2, done_cyc: 68};
    vecs[3] = '{sel: 0, vlen: 40, len: 32, lat: 2, done_cyc: 68};
    vecs[4] = '{sel: 0, vlen: 5,  len: 5,  lat: 2, done_cyc: 14};
    vecs[5] = '{sel: 1, vlen: 4,  len: 4,  lat: 1, done_cyc: 11};

    for (int i = 0; i < 64; i++) begin
      wmem[i] = 8'(i * 37 + 11);
      imem[i] = 8'(i * 91 + 7);
    end
    wmem[0] = 8'hFE; wmem[1] = 8'h6B; wmem[2] = 8'hF0; wmem[31] = 8'hC2;
    imem[0] = 8'h35; imem[1] = 8'h02; imem[2] = 8'hD5; imem[31] = 8'h09;

    reset = 1'b1;
    for (int s = 0; s < 2; s++) begin
      start_v[s] = 1'b0;
      vlen_v[s]  = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_quiet(0, 0, 1'b1);
    chk_quiet(1, 0, 1'b1);
    reset = 1'b0;
    @(negedge clk);

    foreach (vecs[k]) begin
      run_job(vecs[k].sel, vecs[k].vlen, vecs[k].len, vecs[k].lat, vecs[k].done_cyc, 1'b0);
      @(negedge clk);
    end

    // start held high: the second job's CLR must follow the first job's done cycle.
    run_job(0, 2, 2, 2, 8, 1'b1);
    run_job(0, 2, 2, 2, 8, 1'b0);
    @(negedge clk);

    // Mid-job reset: everything clears the next cycle and the job never completes.
    start_v[0] = 1'b1;
    vlen_v[0]  = AW'(32);
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (c == 1) start_v[0] = 1'b0;
    end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk_quiet(0, 21, 1'b1);
    for (int c = 22; c <= 70; c++) begin
      @(posedge clk);
      @(negedge clk);
      chk("done_abort", c, 32'(done_v[0]), 0);
      chk("busy_abort", c, 32'(busy_v[0]), 0);
    end
    run_job(0, 3, 3, 2, 10, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
